mma_result_drain: RTL and testbench

//  Downstream stage of the tile-level MMA wrapper: accepts one full result tile D[M][N] (4P-bit

---
 rtl/mma_pkg.sv | 31 +++
 rtl/mma_sat.sv | 24 ++
 rtl/mma_result_drain.sv | 113 +++++++++++
 tb/tb_mma_result_drain.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mma_pkg.sv
// Shared types and sizing helpers for the MMA result drain.
package mma_pkg;

    localparam int P_DEF  = 8;
    localparam int M_DEF  = 8;
    localparam int N_DEF  = 4;
    localparam int E_DEF  = 4;

    // Accumulator element at the default operand precision.
    typedef logic signed [4*P_DEF-1:0] acc_t;

    // Tile-slot occupancy; doubles as the drain controller state.
    typedef enum logic [1:0] {
        SLOTS_EMPTY = 2'd0,
        SLOTS_ONE   = 2'd1,
        SLOTS_FULL  = 2'd2
    } slots_t;

    function automatic int beats_f(input int m, input int n, input int e);
        return (m * n) / e;
    endfunction

    // Beat counter width, never narrower than one bit.
    function automatic int beat_w_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int BEATS  = beats_f(M_DEF, N_DEF, E_DEF);
    localparam int BEAT_W = beat_w_f(BEATS);

endpackage

// File: rtl/mma_sat.sv
// One-lane signed clamp from accumulator width to output width with a clip flag.
module mma_sat #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 32
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic        [OUT_W-1:0] out_o,
    output logic                    clip_o
);

    if (OUT_W == ACC_W) begin : g_pass
        assign out_o  = acc_i;
        assign clip_o = 1'b0;
    end else begin : g_clamp
        logic fits;
        // The value fits when every bit above the output sign bit equals the sign.
        assign fits   = (acc_i[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){acc_i[ACC_W-1]}});
        assign clip_o = !fits;
        assign out_o  = fits ? acc_i[OUT_W-1:0]
                      : (acc_i[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}});
    end

endmodule

// File: rtl/mma_result_drain.sv
// Ping-pong tile buffer that streams MMA result tiles row-major, E elements per beat.
//
// state        | meaning
// SLOTS_EMPTY  | no tile held, valid_o low
// SLOTS_ONE    | one tile held and draining, other slot free
// SLOTS_FULL   | both slots held, ready_o low
module mma_result_drain
    import mma_pkg::*;
#(
    parameter int M     = 8,
    parameter int N     = 4,
    parameter int P     = 8,
    parameter int E     = 4,
    parameter int OUT_W = 32,
    localparam int ACC_W   = 4 * P,
    localparam int NBEATS  = beats_f(M, N, E),
    localparam int NBEAT_W = beat_w_f(NBEATS)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [M-1:0][N-1:0][ACC_W-1:0]     D_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output logic [E-1:0][OUT_W-1:0]            data_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic                               last_o,
    output logic [NBEAT_W-1:0]                 beat_o,
    input  logic                               clr_sat_i,
    output logic                               sat_o
);

    localparam int TILE_W = M * N * ACC_W;

    if ((N % E) != 0) begin : g_bad_e
        $error("mma_result_drain: E must divide N");
    end
    if (OUT_W < 2 || OUT_W > ACC_W) begin : g_bad_out_w
        $error("mma_result_drain: OUT_W must be in [2, 4*P]");
    end

    slots_t               state_q, state_d;
    logic [TILE_W-1:0]    slot_q [2];
    logic                 head_q, tail_q;
    logic [NBEAT_W-1:0]   beat_q, beat_d;
    logic                 sat_q, sat_d;
    logic                 push, xfer, fin;
    logic [E-1:0]         clip;
    logic [TILE_W-1:0]    head_tile;

    assign ready_o   = !rst_i && (state_q != SLOTS_FULL);
    assign valid_o   = (state_q != SLOTS_EMPTY);
    assign last_o    = valid_o && (beat_q == NBEAT_W'(NBEATS - 1));
    assign beat_o    = beat_q;
    assign sat_o     = sat_q;
    assign push      = valid_i && ready_o;
    assign xfer      = valid_o && ready_i;
    assign fin       = xfer && last_o;
    assign head_tile = slot_q[head_q];

    // Packed tile layout puts element [r][c] at flat index r*N+c, so beat b lane e is b*E+e.
    for (genvar e = 0; e < E; e++) begin : g_lane
        logic signed [ACC_W-1:0] acc;
        assign acc = head_tile[(int'(beat_q) * E + e) * ACC_W +: ACC_W];
        mma_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat (
            .acc_i  (acc),
            .out_o  (data_o[e]),
            .clip_o (clip[e])
        );
    end

    // Next occupancy, beat position and sticky saturation flag.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        sat_d   = sat_q;
        case (state_q)
            SLOTS_EMPTY: if (push) state_d = SLOTS_ONE;
            SLOTS_ONE: begin
                if (push && !fin)      state_d = SLOTS_FULL;
                else if (!push && fin) state_d = SLOTS_EMPTY;
            end
            SLOTS_FULL:  if (fin) state_d = SLOTS_ONE;
            default:     state_d = SLOTS_EMPTY;
        endcase
        if (xfer) beat_d = fin ? '0 : beat_q + 1'b1;
        if (xfer && (|clip)) sat_d = 1'b1;
        else if (clr_sat_i)  sat_d = 1'b0;
    end

    // Control registers; reset discards any held or partially drained tile.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= SLOTS_EMPTY;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            beat_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            sat_q   <= sat_d;
            if (push) tail_q <= ~tail_q;
            if (fin)  head_q <= ~head_q;
        end
    end

    // Tile storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) slot_q[tail_q] <= D_i;
    end

endmodule

// File: tb/tb_mma_result_drain.sv
// Directed bench for mma_result_drain: default config, OUT_W=16 and E=2 instances.
module tb_mma_result_drain;

    typedef logic [7:0][3:0][31:0] tile_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // u0: defaults
    tile_t             d0;
    logic              v0 = 1'b0, r0 = 1'b0, clr0 = 1'b0;
    logic              rdy0, val0, last0, sat0;
    logic [3:0][31:0]  dat0;
    logic [2:0]        beat0;
    // u1: OUT_W=16
    tile_t             d1;
    logic              v1 = 1'b0, r1 = 1'b0, clr1 = 1'b0;
    logic              rdy1, val1, last1, sat1;
    logic [3:0][15:0]  dat1;
    logic [2:0]        beat1;
    // u2: E=2
    tile_t             d2;
    logic              v2 = 1'b0, r2 = 1'b0, clr2 = 1'b0;
    logic              rdy2, val2, last2, sat2;
    logic [1:0][31:0]  dat2;
    logic [3:0]        beat2;

    mma_result_drain u0 (
        .clk_i(clk), .rst_i(rst), .D_i(d0), .valid_i(v0), .ready_o(rdy0),
        .data_o(dat0), .valid_o(val0), .ready_i(r0), .last_o(last0),
        .beat_o(beat0), .clr_sat_i(clr0), .sat_o(sat0));

    mma_result_drain #(.OUT_W(16)) u1 (
        .clk_i(clk), .rst_i(rst), .D_i(d1), .valid_i(v1), .ready_o(rdy1),
        .data_o(dat1), .valid_o(val1), .ready_i(r1), .last_o(last1),
        .beat_o(beat1), .clr_sat_i(clr1), .sat_o(sat1));

    mma_result_drain #(.E(2)) u2 (
        .clk_i(clk), .rst_i(rst), .D_i(d2), .valid_i(v2), .ready_o(rdy2),
        .data_o(dat2), .valid_o(val2), .ready_i(r2), .last_o(last2),
        .beat_o(beat2), .clr_sat_i(clr2), .sat_o(sat2));

    function automatic tile_t mk(input int base);
        tile_t t;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = 32'(base + r * 4 + c);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model for u0: queue of held tile bases, occupancy and beat position.
    int exp_q[$];
    int exp_cnt  = 0;
    int exp_beat = 0;
    int cur_base0 = 0;
    int nvalid0   = 0;

    // Check u0 outputs against the model, then clock once and advance the model.
    task automatic tick0();
        bit push, xfer, fin;
        chk("valid0", 64'(val0), 64'(exp_cnt != 0));
        chk("ready0", 64'(rdy0), 64'(exp_cnt < 2));
        if (exp_cnt != 0) begin
            nvalid0++;
            chk("beat0", 64'(beat0), 64'(exp_beat));
            chk("last0", 64'(last0), 64'(exp_beat == 7));
            for (int e = 0; e < 4; e++)
                chk("data0", 64'(dat0[e]), 64'(32'(exp_q[0] + exp_beat * 4 + e)));
        end
        push = v0 && (exp_cnt < 2);
        xfer = (exp_cnt != 0) && r0;
        fin  = xfer && (exp_beat == 7);
        step();
        if (push) exp_q.push_back(cur_base0);
        if (fin) void'(exp_q.pop_front());
        exp_cnt = exp_cnt + int'(push) - int'(fin);
        if (xfer) exp_beat = fin ? 0 : exp_beat + 1;
    endtask

    initial begin
        int sent;
        int iters;
        int bases[3];

        d0 = '0; d1 = '0; d2 = '0;

        // Reset state
        step();
        chk("rst_ready0", 64'(rdy0), 64'd0);
        chk("rst_valid0", 64'(val0), 64'd0);
        chk("rst_last0",  64'(last0), 64'd0);
        chk("rst_beat0",  64'(beat0), 64'd0);
        chk("rst_sat0",   64'(sat0), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready0", 64'(rdy0), 64'd1);

        // Test 1: single tile, hand-checked beats
        d0 = mk(0); v0 = 1'b1; r0 = 1'b1;
        step();
        v0 = 1'b0;
        chk("t1_latency", 64'(val0), 64'd1);
        for (int k = 0; k < 8; k++) begin
            chk("t1_beat", 64'(beat0), 64'(k));
            chk("t1_last", 64'(last0), 64'(k == 7));
            for (int e = 0; e < 4; e++)
                chk("t1_data", 64'(dat0[e]), 64'(4 * k + e));
            step();
        end
        chk("t1_done", 64'(val0), 64'd0);
        chk("t1_sat", 64'(sat0), 64'd0);

        // Test 2: three tiles back-to-back, expect 24 gapless beats after one accept cycle
        bases[0] = 100; bases[1] = 200; bases[2] = 300;
        sent = 0; iters = 0; nvalid0 = 0;
        while ((sent < 3 || exp_cnt != 0) && iters < 60) begin
            bit will_push;
            if (sent < 3) begin
                v0 = 1'b1; cur_base0 = bases[sent]; d0 = mk(cur_base0);
            end else v0 = 1'b0;
            will_push = v0 && (exp_cnt < 2);
            tick0();
            if (will_push) sent++;
            iters++;
        end
        v0 = 1'b0;
        chk("t2_cycles", 64'(iters), 64'd25);
        chk("t2_beats", 64'(nvalid0), 64'd24);
        chk("t2_done", 64'(val0), 64'd0);

        // Test 3: stall mid-tile while a second tile is accepted
        cur_base0 = 400; d0 = mk(400); v0 = 1'b1; r0 = 1'b1;
        tick0();
        v0 = 1'b0;
        tick0(); tick0(); tick0();
        r0 = 1'b0; cur_base0 = 500; d0 = mk(500); v0 = 1'b1;
        tick0();
        v0 = 1'b0;
        for (int i = 0; i < 9; i++) tick0();
        chk("t3_ready_full", 64'(rdy0), 64'd0);
        chk("t3_frozen_beat", 64'(beat0), 64'd3);
        chk("t3_frozen_data", 64'(dat0[0]), 64'd412);
        r0 = 1'b1;
        for (int i = 0; i < 40 && exp_cnt != 0; i++) tick0();
        chk("t3_drained", 64'(val0), 64'd0);

        // Test 4: saturation on the OUT_W=16 instance
        d1 = '0;
        d1[0][0] = 32'sd40000;  d1[0][1] = -32'sd40000;
        d1[0][2] = 32'sd5;      d1[0][3] = -32'sd5;
        d1[2][3] = 32'sd100000;
        d1[3][0] = 32'sd32767;  d1[3][1] = -32'sd32768;
        d1[3][2] = 32'sd32768;  d1[3][2] = 32'sd1;
        v1 = 1'b1; r1 = 1'b0;
        step();
        v1 = 1'b0;
        chk("t4_valid", 64'(val1), 64'd1);
        chk("t4_pos_clip", 64'(dat1[0]), 64'h7fff);
        chk("t4_neg_clip", 64'(dat1[1]), 64'h8000);
        chk("t4_small_pos", 64'(dat1[2]), 64'h0005);
        chk("t4_small_neg", 64'(dat1[3]), 64'hfffb);
        chk("t4_sat_pre", 64'(sat1), 64'd0);
        r1 = 1'b1;
        step();
        chk("t4_sat_set", 64'(sat1), 64'd1);
        chk("t4_beat1", 64'(beat1), 64'd1);
        clr1 = 1'b1;
        step();
        chk("t4_clr_noclip", 64'(sat1), 64'd0);
        chk("t4_b2_clip", 64'(dat1[3]), 64'h7fff);
        chk("t4_b2_zero", 64'(dat1[0]), 64'h0000);
        step();
        chk("t4_set_wins", 64'(sat1), 64'd1);
        chk("t4_max_exact", 64'(dat1[0]), 64'h7fff);
        chk("t4_min_exact", 64'(dat1[1]), 64'h8000);
        chk("t4_one", 64'(dat1[2]), 64'h0001);
        step();
        chk("t4_clr_exact", 64'(sat1), 64'd0);
        clr1 = 1'b0;
        step(); step(); step();
        chk("t4_last", 64'(last1), 64'd1);
        chk("t4_beat7", 64'(beat1), 64'd7);
        step();
        chk("t4_done", 64'(val1), 64'd0);

        // Test 6: E=2 instance, 16 beats row-major
        d2 = mk(900); v2 = 1'b1; r2 = 1'b1;
        step();
        v2 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("t6_valid", 64'(val2), 64'd1);
            chk("t6_beat", 64'(beat2), 64'(k));
            chk("t6_last", 64'(last2), 64'(k == 15));
            chk("t6_e0", 64'(dat2[0]), 64'(900 + 2 * k));
            chk("t6_e1", 64'(dat2[1]), 64'(901 + 2 * k));
            step();
        end
        chk("t6_done", 64'(val2), 64'd0);

        // Test 5: reset during beat 3 with two tiles held
        r0 = 1'b1; cur_base0 = 600; d0 = mk(600); v0 = 1'b1;
        tick0();
        cur_base0 = 700; d0 = mk(700);
        tick0();
        v0 = 1'b0;
        tick0(); tick0();
        chk("t5_beat3", 64'(beat0), 64'd3);
        chk("t5_full", 64'(rdy0), 64'd0);
        rst = 1'b1;
        #1;
        chk("t5_valid_async", 64'(val0), 64'd0);
        chk("t5_ready_rst", 64'(rdy0), 64'd0);
        chk("t5_beat_rst", 64'(beat0), 64'd0);
        chk("t5_last_rst", 64'(last0), 64'd0);
        exp_q.delete(); exp_cnt = 0; exp_beat = 0;
        step();
        chk("t5_ready_hold", 64'(rdy0), 64'd0);
        chk("t5_valid_hold", 64'(val0), 64'd0);
        rst = 1'b0;
        #1;
        chk("t5_ready_rel", 64'(rdy0), 64'd1);
        chk("t5_valid_rel", 64'(val0), 64'd0);
        cur_base0 = 800; d0 = mk(800); v0 = 1'b1;
        tick0();
        v0 = 1'b0;
        chk("t5_new_first", 64'(dat0[0]), 64'd800);
        for (int i = 0; i < 8; i++) tick0();
        chk("t5_done", 64'(val0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
